// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer.
// Each channel runs its own four-state debounce FSM (LOW, CHECK_HIGH, HIGH,
// CHECK_LOW), a debounce counter and a hold timer. All outputs are flops.
// The output stage is one cycle behind the FSM state. As a result, button_o
// changes exactly DEBOUNCE_CYCLES_P edges after the first edge that samples
// the new raw level.
// press_o and release_o pulse in the cycle where button_o first shows the
// new level.
// hold_o pulses HOLD_CYCLES_P cycles after press_o, at most once per
// accepted press. A bounce that stays inside CHECK_LOW does not restart it.
// state_dbg_o exposes every channel's FSM state, two bits per channel.
// Channel g occupies bits [2g+1:2g].
module button_debounce #(
    parameter int WIDTH_P           = 3,
    parameter int DEBOUNCE_CYCLES_P = 250000,
    parameter int HOLD_CYCLES_P     = 25000000
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [WIDTH_P-1:0]     button_i,
    output logic [WIDTH_P-1:0]     button_o,
    output logic [WIDTH_P-1:0]     press_o,
    output logic [WIDTH_P-1:0]     release_o,
    output logic [WIDTH_P-1:0]     hold_o,
    output logic [2*WIDTH_P-1:0]   state_dbg_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES_P) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES_P) + 1;

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES_P - 1);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES_P);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_LOW        = 2'd0,
        ST_CHECK_HIGH = 2'd1,
        ST_HIGH       = 2'd2,
        ST_CHECK_LOW  = 2'd3
    } state_e;

    for (genvar g = 0; g < WIDTH_P; g++) begin : g_chan
        state_e              state_q;
        logic [DB_W-1:0]     db_cnt_q;
        logic [HOLD_W-1:0]   hold_cnt_q;
        logic                hold_done_q;
        logic                level_q;
        logic                press_q;
        logic                release_q;
        logic                hold_q;
        logic                level_now;

        // Debounced level implied by the current FSM state; button_o is this delayed one cycle.
        assign level_now = (state_q == ST_HIGH) || (state_q == ST_CHECK_LOW);

        // Debounce FSM, hold timer and registered pulse outputs for one channel.
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                state_q     <= ST_LOW;
                db_cnt_q    <= '0;
                hold_cnt_q  <= '0;
                hold_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                hold_q      <= 1'b0;
            end else begin
                level_q   <= level_now;
                press_q   <= level_now & ~level_q;
                release_q <= ~level_now & level_q;
                hold_q    <= (hold_cnt_q == HOLD_MAX) & ~hold_done_q;
                if (hold_cnt_q == HOLD_MAX) begin
                    hold_done_q <= 1'b1;
                end
                // The hold timer runs through CHECK_LOW bounces and saturates at HOLD_MAX.
                if (level_now && (hold_cnt_q != HOLD_MAX)) begin
                    hold_cnt_q <= hold_cnt_q + HOLD_ONE;
                end

                case (state_q)
                    ST_LOW: begin
                        if (button_i[g]) begin
                            state_q  <= ST_CHECK_HIGH;
                            db_cnt_q <= DB_ONE;
                        end else begin
                            db_cnt_q <= '0;
                        end
                    end
                    ST_CHECK_HIGH: begin
                        if (!button_i[g]) begin
                            state_q     <= ST_LOW;
                            db_cnt_q    <= '0;
                            hold_cnt_q  <= '0;
                            hold_done_q <= 1'b0;
                        end else if (db_cnt_q == DB_LAST) begin
                            state_q     <= ST_HIGH;
                            db_cnt_q    <= '0;
                            hold_cnt_q  <= '0;
                            hold_done_q <= 1'b0;
                        end else begin
                            db_cnt_q <= db_cnt_q + DB_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (!button_i[g]) begin
                            state_q  <= ST_CHECK_LOW;
                            db_cnt_q <= DB_ONE;
                        end
                    end
                    ST_CHECK_LOW: begin
                        if (button_i[g]) begin
                            state_q  <= ST_HIGH;
                            db_cnt_q <= '0;
                        end else if (db_cnt_q == DB_LAST) begin
                            state_q     <= ST_LOW;
                            db_cnt_q    <= '0;
                            hold_cnt_q  <= '0;
                            hold_done_q <= 1'b0;
                        end else begin
                            db_cnt_q <= db_cnt_q + DB_ONE;
                        end
                    end
                    default: begin
                        state_q  <= ST_LOW;
                        db_cnt_q <= '0;
                    end
                endcase
            end
        end

        assign button_o[g]             = level_q;
        assign press_o[g]              = press_q;
        assign release_o[g]            = release_q;
        assign hold_o[g]               = hold_q;
        assign state_dbg_o[2*g +: 2]   = state_q;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL provide parameter WIDTH_P, default 3, number of independent button channels (1..8).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES_P, default 250000, consecutive stable cycles needed to accept a new level (10 ms at 25 MHz); legal range 2..2^24.
REQ-003 SHALL provide parameter HOLD_CYCLES_P, default 25000000, cycles a debounced press must persist before a hold event (1 s at 25 MHz); legal range 1..2^28.
REQ-004 SHALL have port clk_i  input  1  single clock; one clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port button_i  input  WIDTH_P  raw button levels, already two-flop synchronized upstream; not debounced; 1 = pressed.
REQ-007 SHALL have port button_o  output  WIDTH_P  debounced level per channel, registered.
REQ-008 SHALL have port press_o  output  WIDTH_P  one-cycle pulse per channel on an accepted 0->1 transition.
REQ-009 SHALL have port release_o  output  WIDTH_P  one-cycle pulse per channel on an accepted 1->0 transition.
REQ-010 SHALL have port hold_o  output  WIDTH_P  one-cycle pulse per channel when a press has persisted HOLD_CYCLES_P cycles.

Function
REQ-011 Each channel SHALL be fully independent: own FSM, debounce counter, hold counter; no shared state.
REQ-012 Per-channel FSM SHALL have states LOW, CHECK_HIGH, HIGH, CHECK_LOW; button_o = 1 in HIGH and CHECK_LOW, 0 otherwise.
REQ-013 LOW: sample 1 -> CHECK_HIGH, debounce counter loaded with 1; sample 0 -> stay.
REQ-014 CHECK_HIGH: sample 0 -> LOW, counter cleared (glitch rejected, no pulse); sample 1 with counter = DEBOUNCE_CYCLES_P-1 -> HIGH; otherwise counter+1.
REQ-015 HIGH: sample 0 -> CHECK_LOW, counter loaded with 1; sample 1 -> stay.
REQ-016 CHECK_LOW: sample 1 -> HIGH, counter cleared (no pulse); sample 0 with counter = DEBOUNCE_CYCLES_P-1 -> LOW; otherwise counter+1.
REQ-017 Latency: after button_i changes and stays constant, button_o SHALL change exactly DEBOUNCE_CYCLES_P cycles after the first clock edge sampling the new value.
REQ-018 press_o SHALL be high for exactly the one cycle in which button_o first reads 1 after CHECK_HIGH->HIGH; release_o likewise for CHECK_LOW->LOW.
REQ-019 Hold counter SHALL clear on entry to HIGH from CHECK_HIGH, increment each cycle in HIGH or CHECK_LOW, saturate after hold fires, clear on entry to LOW.
REQ-020 hold_o SHALL pulse for one cycle when the hold counter reaches HOLD_CYCLES_P, at most once per accepted press; a CHECK_LOW bounce back to HIGH SHALL NOT restart the hold count.
REQ-021 Counter widths SHALL be $clog2 of the respective parameter + 1; counters SHALL never wrap.
REQ-022 press_o, release_o, hold_o SHALL never be high simultaneously on one channel except hold_o with no other pulse; press_o and release_o never in consecutive cycles (minimum DEBOUNCE_CYCLES_P apart).
REQ-023 All outputs SHALL be driven directly from flops; no combinational path from button_i to any output.

Reset
REQ-024 While reset_n_i = 0 at a rising edge, every channel SHALL enter LOW with both counters 0; button_o, press_o, release_o, hold_o SHALL all read 0 the following cycle.
REQ-025 Reset mid-CHECK or mid-hold SHALL discard the pending transition; no pulse SHALL be emitted on or after reset release until a fresh full debounce completes.
REQ-026 A button held at 1 through reset release SHALL produce press_o DEBOUNCE_CYCLES_P cycles after the first post-reset edge sampling 1.

Verification (DEBOUNCE_CYCLES_P=4, HOLD_CYCLES_P=8, WIDTH_P=3)
REQ-027 Clean press: button_i[0] 0->1 held -> button_o[0]=1 and press_o[0]=1 exactly 4 cycles after first sampling edge, press_o low next cycle.
REQ-028 Glitch: button_i[1]=1 for 3 cycles then 0 -> button_o[1] stays 0, no pulses on any output.
REQ-029 Release bounce: in HIGH, drive 0,1,0,0,0,0 -> only the final run of four 0s accepted; single release_o[x] pulse, hold_o count not restarted by the bounce.
REQ-030 Hold: press held 20 cycles -> hold_o pulses once, 8 cycles after press_o, never again until release and re-press.
REQ-031 Reset mid-CHECK_HIGH (counter=2), button still 1 -> outputs 0 during reset; press_o 4 cycles after first post-reset sample of 1.
REQ-032 Independence: channels 0 and 2 pressed on the same edge, channel 1 bouncing -> press_o = 3'b101 in one cycle, channel 1 silent.
